pipe_arbiter_ctrl: RTL and testbench

- Shares one 3-operand arithmetic pipeline (10-bit in1/in2/in3, result out) between two requesters.
- Round-robin arbitrates valid/ready requests and registers the winner's operands onto the pipeline inputs.
- Tracks in-flight operations with a tag shift register and routes each result back, tagged with its requester ID.
- Provides a flush/drain sequence so the owner can quiesce the pipeline before reset or reconfiguration.

---
 rtl/pipe_arbiter_ctrl_if.sv | 43 ++++
 rtl/pipe_arbiter_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_arbiter_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_arbiter_ctrl_if.sv
// Bundles the handshake and pipeline signals of pipe_arbiter_ctrl.
// master: the requester/pipeline side, slave: the arbiter.
interface pipe_arbiter_ctrl_if #(
    parameter int DATA_W = 10,
    parameter int OUT_W  = 21
);
    logic              r0_valid;
    logic              r0_ready;
    logic [DATA_W-1:0] r0_in1;
    logic [DATA_W-1:0] r0_in2;
    logic [DATA_W-1:0] r0_in3;
    logic              r1_valid;
    logic              r1_ready;
    logic [DATA_W-1:0] r1_in1;
    logic [DATA_W-1:0] r1_in2;
    logic [DATA_W-1:0] r1_in3;
    logic [DATA_W-1:0] pipe_in1;
    logic [DATA_W-1:0] pipe_in2;
    logic [DATA_W-1:0] pipe_in3;
    logic [OUT_W-1:0]  pipe_out;
    logic              res_valid;
    logic              res_id;
    logic [OUT_W-1:0]  res_data;
    logic              flush_req;
    logic              flush_done;
    logic              busy;

    modport master (
        output r0_valid, r0_in1, r0_in2, r0_in3,
        output r1_valid, r1_in1, r1_in2, r1_in3,
        output pipe_out, flush_req,
        input  r0_ready, r1_ready, pipe_in1, pipe_in2, pipe_in3,
        input  res_valid, res_id, res_data, flush_done, busy
    );

    modport slave (
        input  r0_valid, r0_in1, r0_in2, r0_in3,
        input  r1_valid, r1_in1, r1_in2, r1_in3,
        input  pipe_out, flush_req,
        output r0_ready, r1_ready, pipe_in1, pipe_in2, pipe_in3,
        output res_valid, res_id, res_data, flush_done, busy
    );
endinterface

// File: rtl/pipe_arbiter_ctrl.sv
// Two-requester round-robin front end for a shared 3-operand pipeline.
// Tracks in-flight ops with a tag shift register, returns tagged results,
// and offers a flush/drain handshake.
// Optional per-requester completion counters: define PIPE_ARB_STATS_EN.
module pipe_arbiter_ctrl #(
    parameter int DATA_W = 10,
    parameter int OUT_W  = 21,
    parameter int LAT    = 3,
    parameter int CNT_W  = 3
) (
    input logic clk,
    input logic rst_n,
    pipe_arbiter_ctrl_if.slave bus
`ifdef PIPE_ARB_STATS_EN
    ,
    output logic [15:0] r0_done_cnt,
    output logic [15:0] r1_done_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t           state;
    logic             rr_ptr;      // 1: r1 is favoured on contention
    logic [LAT:0]     tag_v;
    logic [LAT:0]     tag_id;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;
    logic             grant_id;

    // Round-robin grant; flush_req and DRAIN suppress both readies
    always_comb begin
        bus.r0_ready = 1'b0;
        bus.r1_ready = 1'b0;
        if (state != DRAIN && !bus.flush_req) begin
            if (bus.r0_valid && (!bus.r1_valid || !rr_ptr))
                bus.r0_ready = 1'b1;
            else if (bus.r1_valid)
                bus.r1_ready = 1'b1;
        end
    end

    assign accept   = bus.r0_ready | bus.r1_ready;
    assign grant_id = bus.r1_ready;

    // Next in-flight count: +1 on accept, -1 on result, both cancel
    always_comb begin
        cnt_nxt = cnt;
        if (accept && !bus.res_valid)
            cnt_nxt = cnt + 1'b1;
        else if (!accept && bus.res_valid)
            cnt_nxt = cnt - 1'b1;
    end

    // Register winner operands (bubble = zeros) and advance the RR pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pipe_in1 <= '0;
            bus.pipe_in2 <= '0;
            bus.pipe_in3 <= '0;
            rr_ptr       <= 1'b0;
        end else begin
            if (bus.r0_ready) begin
                bus.pipe_in1 <= bus.r0_in1;
                bus.pipe_in2 <= bus.r0_in2;
                bus.pipe_in3 <= bus.r0_in3;
            end else if (bus.r1_ready) begin
                bus.pipe_in1 <= bus.r1_in1;
                bus.pipe_in2 <= bus.r1_in2;
                bus.pipe_in3 <= bus.r1_in3;
            end else begin
                bus.pipe_in1 <= '0;
                bus.pipe_in2 <= '0;
                bus.pipe_in3 <= '0;
            end
            if (accept)
                rr_ptr <= ~grant_id;
        end
    end

    // Tag shift register: stage 0 plus LAT stages, mirroring the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[LAT-1:0], accept};
            tag_id <= {tag_id[LAT-1:0], grant_id};
        end
    end

    assign bus.res_valid = tag_v[LAT];
    assign bus.res_id    = tag_id[LAT];
    assign bus.res_data  = bus.res_valid ? bus.pipe_out : '0;
    assign bus.busy      = (cnt != '0);

    // Control FSM with in-flight counter and registered flush_done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.flush_done <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            bus.flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush_req)
                        state <= DRAIN;
                    else if (accept)
                        state <= ACTIVE;
                end
                ACTIVE: begin
                    if (bus.flush_req)
                        state <= DRAIN;
                    else if (cnt_nxt == '0)
                        state <= IDLE;
                end
                DRAIN: begin
                    // Looking at cnt_nxt puts the pulse right after the last result
                    if (cnt_nxt == '0) begin
                        bus.flush_done <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIPE_ARB_STATS_EN
    // Saturating per-requester completion counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_done_cnt <= '0;
            r1_done_cnt <= '0;
        end else if (bus.res_valid) begin
            if (!bus.res_id && r0_done_cnt != '1)
                r0_done_cnt <= r0_done_cnt + 1'b1;
            if (bus.res_id && r1_done_cnt != '1)
                r1_done_cnt <= r1_done_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_arbiter_ctrl.sv
// Scoreboard bench for pipe_arbiter_ctrl with a 3-stage (a+b)*c pipeline model.
// Optional counters are checked when PIPE_ARB_STATS_EN is defined.
module tb_pipe_arbiter_ctrl;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [21:0] sb[$];
    logic [20:0] p1, p2, p3;

    pipe_arbiter_ctrl_if #(.DATA_W(10), .OUT_W(21)) bus ();

`ifdef PIPE_ARB_STATS_EN
    logic [15:0] r0_done_cnt, r1_done_cnt, s0, s1;
`endif

    pipe_arbiter_ctrl #(.DATA_W(10), .OUT_W(21), .LAT(3), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PIPE_ARB_STATS_EN
        ,
        .r0_done_cnt (r0_done_cnt),
        .r1_done_cnt (r1_done_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipeline model: three register stages from pipe_in* to pipe_out
    always @(posedge clk) begin
        p1 <= (21'(bus.pipe_in1) + 21'(bus.pipe_in2)) * 21'(bus.pipe_in3);
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.pipe_out = p3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is presented
    always @(negedge clk) begin
        logic [21:0] e;
        if (rst_n === 1'b1) begin
            checks++;
            if (bus.r0_ready === 1'b1 && bus.r1_ready === 1'b1) begin
                errors++;
                $display("FAIL ready_exclusive: got both high expected at most one");
            end
            if (bus.res_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id=%0d data=%0d expected none",
                             bus.res_id, bus.res_data);
                end else begin
                    e = sb.pop_front();
                    chk("mon_res_id", 32'(bus.res_id), 32'(e[21]));
                    chk("mon_res_data", 32'(bus.res_data), 32'(e[20:0]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [9:0] a0, b0, c0,
                         input logic v1, input logic [9:0] a1, b1, c1);
        bus.r0_valid = v0; bus.r0_in1 = a0; bus.r0_in2 = b0; bus.r0_in3 = c0;
        bus.r1_valid = v1; bus.r1_in1 = a1; bus.r1_in2 = b1; bus.r1_in3 = c1;
    endtask

    // Check readies mid-cycle, queue the expected result, then take the edge
    task automatic grant(input string name, input logic e0, input logic e1,
                         input logic [20:0] data, input bit push);
        #2;
        chk({name, ".r0_ready"}, 32'(bus.r0_ready), 32'(e0));
        chk({name, ".r1_ready"}, 32'(bus.r1_ready), 32'(e1));
        if (push && e0) sb.push_back({1'b0, data});
        if (push && e1) sb.push_back({1'b1, data});
        step();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0 && bus.busy === 1'b0) break;
            step();
        end
        chk({name, ".queue_empty"}, 32'(sb.size()), 32'd0);
        chk({name, ".busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, ".pipe_in1"}, 32'(bus.pipe_in1), 32'd0);
        chk({name, ".pipe_in2"}, 32'(bus.pipe_in2), 32'd0);
        chk({name, ".pipe_in3"}, 32'(bus.pipe_in3), 32'd0);
        chk({name, ".res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({name, ".res_id"}, 32'(bus.res_id), 32'd0);
        chk({name, ".res_data"}, 32'(bus.res_data), 32'd0);
        chk({name, ".flush_done"}, 32'(bus.flush_done), 32'd0);
        chk({name, ".busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic rv[5];
        logic fd[5];
        rst_n = 1'b0;
        bus.flush_req = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk_zero_outputs("reset");
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Single op from r0: (1+2)*3 = 9, visible 4 edges after accept
        drive(1, 1, 2, 3, 0, 0, 0, 0);
        grant("single", 1, 0, 21'd9, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("single.pipe_in1", 32'(bus.pipe_in1), 32'd1);
        chk("single.pipe_in2", 32'(bus.pipe_in2), 32'd2);
        chk("single.pipe_in3", 32'(bus.pipe_in3), 32'd3);
        chk("single.res_valid_e1", 32'(bus.res_valid), 32'd0);
        chk("single.busy", 32'(bus.busy), 32'd1);
        step(); #2;
        chk("single.bubble_in1", 32'(bus.pipe_in1), 32'd0);
        chk("single.res_valid_e2", 32'(bus.res_valid), 32'd0);
        step(); #2;
        chk("single.res_valid_e3", 32'(bus.res_valid), 32'd0);
        step(); #2;
        chk("single.res_valid_e4", 32'(bus.res_valid), 32'd1);
        chk("single.res_id", 32'(bus.res_id), 32'd0);
        chk("single.res_data", 32'(bus.res_data), 32'd9);
        wait_drain("single");

        // Back-to-back from r0: 9, (4+5)*6 = 54, (7+8)*9 = 135
        drive(1, 1, 2, 3, 0, 0, 0, 0);
        grant("b2b0", 1, 0, 21'd9, 1);
        drive(1, 4, 5, 6, 0, 0, 0, 0);
        grant("b2b1", 1, 0, 21'd54, 1);
        drive(1, 7, 8, 9, 0, 0, 0, 0);
        grant("b2b2", 1, 0, 21'd135, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("b2b.count_peak", 32'(dut.cnt), 32'd3);
        wait_drain("b2b");

        // Lone r1 op: (3+3)*3 = 18; leaves the pointer favouring r0
        drive(0, 0, 0, 0, 1, 3, 3, 3);
        grant("r1solo", 0, 1, 21'd18, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        wait_drain("r1solo");

        // Contention: grants alternate r0, r1, r0, r1
`ifdef PIPE_ARB_STATS_EN
        s0 = r0_done_cnt;
        s1 = r1_done_cnt;
`endif
        drive(1, 1, 2, 3, 1, 3, 3, 3);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) grant("contend", 1, 0, 21'd9, 1);
            else            grant("contend", 0, 1, 21'd18, 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        wait_drain("contend");
`ifdef PIPE_ARB_STATS_EN
        chk("stats.r0_delta", 32'(r0_done_cnt - s0), 32'd2);
        chk("stats.r1_delta", 32'(r1_done_cnt - s1), 32'd2);
`endif

        // Flush after two r0 accepts: (2+3)*4 = 20, (10+0)*5 = 50
        drive(1, 2, 3, 4, 0, 0, 0, 0);
        grant("flush_a0", 1, 0, 21'd20, 1);
        drive(1, 10, 0, 5, 0, 0, 0, 0);
        grant("flush_a1", 1, 0, 21'd50, 1);
        bus.flush_req = 1'b1;
        drive(1, 1, 1, 1, 1, 1, 1, 1);
        rv = '{0, 0, 1, 1, 0};
        fd = '{0, 0, 0, 0, 1};
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("flush.r0_ready", 32'(bus.r0_ready), 32'd0);
            chk("flush.r1_ready", 32'(bus.r1_ready), 32'd0);
            chk("flush.res_valid", 32'(bus.res_valid), 32'(rv[i]));
            chk("flush.flush_done", 32'(bus.flush_done), 32'(fd[i]));
            if (i < 4) step();
        end
        bus.flush_req = 1'b0;
        drive(0, 0, 0, 0, 1, 4, 4, 4);
        grant("flush_after", 0, 1, 21'd32, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("flush.done_single_pulse", 32'(bus.flush_done), 32'd0);
        wait_drain("flush");

        // Reset with two ops in flight; those results must never appear
        drive(1, 1, 1, 1, 1, 2, 2, 2);
        grant("rst_a0", 1, 0, 21'd2, 0);
        grant("rst_a1", 0, 1, 21'd8, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("postreset.res_valid", 32'(bus.res_valid), 32'd0);
            step();
        end
        drive(1, 1, 1, 1, 1, 2, 2, 2);
        grant("postreset", 1, 0, 21'd2, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        wait_drain("postreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
